// File: rtl/neuron_mac_relu.sv
// Single neuron: sign-magnitude weight*input MAC onto a bias, rectified once per vector.
// Optional rectifier enabled by NEURON_RELU_EN; otherwise the raw signed sum is emitted.
module neuron_mac_relu #(
  parameter int N_INPUTS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [11:0] in_data,
  input  logic        w_we,
  input  logic [3:0]  w_addr,
  input  logic [11:0] w_data,
  input  logic        b_we,
  input  logic [22:0] b_data,
  output logic        out_valid,
  output logic [22:0] out_data
);

  localparam int IW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_INPUTS - 1);
  localparam logic [4:0]    NI   = 5'(N_INPUTS);

  logic [11:0]   weights [N_INPUTS];
  logic [22:0]   bias;
  logic [22:0]   acc;
  logic [IW-1:0] idx;

  logic [11:0] w_cur;
  logic [21:0] p_mag;
  logic [22:0] product;
  logic [22:0] base;
  logic [22:0] sum;
  logic [22:0] result;
  logic        w_in_range;

  function automatic logic [22:0] sm_add(input logic [22:0] a, input logic [22:0] b);
    logic [22:0] s;
    logic [21:0] mag;
    logic        sgn;
    if (a[22] == b[22]) begin
      s   = {1'b0, a[21:0]} + {1'b0, b[21:0]};
      mag = s[22] ? 22'h3FFFFF : s[21:0];
      sgn = a[22];
    end else if (a[21:0] >= b[21:0]) begin
      mag = a[21:0] - b[21:0];
      sgn = a[22];
    end else begin
      mag = b[21:0] - a[21:0];
      sgn = b[22];
    end
    // Zero is always reported as +0, including exact cancellation.
    if (mag == 22'd0) sgn = 1'b0;
    return {sgn, mag};
  endfunction

  always_comb begin
    w_cur   = weights[idx];
    p_mag   = {11'd0, in_data[10:0]} * {11'd0, w_cur[10:0]};
    product = {(p_mag != 22'd0) & (in_data[11] ^ w_cur[11]), p_mag};
    base    = (idx == '0) ? bias : acc;
    sum     = sm_add(base, product);
`ifdef NEURON_RELU_EN
    result  = sum[22] ? 23'h0 : sum;
`else
    result  = sum;
`endif
  end

  assign w_in_range = ({1'b0, w_addr} < NI);

  // Writes land after the arithmetic reads above, so same-cycle users see the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      acc       <= '0;
      bias      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < N_INPUTS; i++) weights[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        acc <= sum;
        if (idx == LAST) begin
          idx       <= '0;
          out_data  <= result;
          out_valid <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end
      if (b_we) bias <= b_data;
      if (w_we && w_in_range) weights[w_addr[IW-1:0]] <= w_data;
    end
  end

endmodule

// File: tb/tb_neuron_mac_relu.sv
// Scoreboard bench for neuron_mac_relu: integer reference model, expected results queued at drive time.
module tb_neuron_mac_relu;

  localparam int N = 3;
  localparam int SAT = 4194303;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [11:0] in_data = '0;
  logic        w_we = 1'b0;
  logic [3:0]  w_addr = '0;
  logic [11:0] w_data = '0;
  logic        b_we = 1'b0;
  logic [22:0] b_data = '0;
  logic        out_valid;
  logic [22:0] out_data;

  neuron_mac_relu #(.N_INPUTS(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .b_we(b_we), .b_data(b_data),
    .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model state
  logic [11:0] m_w [16];
  logic [22:0] m_bias;
  int          m_idx;
  int          m_acc;
  logic [22:0] hold_exp;
  logic [22:0] q_dat [$];
  int          q_cyc [$];
  logic        mon_en = 1'b0;

  function automatic int sm2int(input logic [22:0] v);
    return v[22] ? -int'(v[21:0]) : int'(v[21:0]);
  endfunction

  function automatic logic [22:0] int2out(input int v);
    logic [22:0] r;
    if (v < 0) r = {1'b1, 22'(-v)};
    else       r = {1'b0, 22'(v)};
`ifdef NEURON_RELU_EN
    if (v < 0) r = 23'h0;
`endif
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_w[i] = '0;
    m_bias = '0;
    m_idx = 0;
    m_acc = 0;
    hold_exp = '0;
  endtask

  task automatic step(input logic v, input logic [11:0] d,
                      input logic wwe, input logic [3:0] wa, input logic [11:0] wd,
                      input logic bwe, input logic [22:0] bd, input logic r);
    int pv, s;
    in_valid = v; in_data = d;
    w_we = wwe; w_addr = wa; w_data = wd;
    b_we = bwe; b_data = bd; rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      if (v) begin
        pv = int'(d[10:0]) * int'(m_w[m_idx][10:0]);
        if (d[11] ^ m_w[m_idx][11]) pv = -pv;
        s = ((m_idx == 0) ? sm2int(m_bias) : m_acc) + pv;
        if (s > SAT)  s = SAT;
        if (s < -SAT) s = -SAT;
        m_acc = s;
        if (m_idx == N - 1) begin
          q_dat.push_back(int2out(s));
          q_cyc.push_back(cyc);
          m_idx = 0;
        end else begin
          m_idx++;
        end
      end
      if (bwe) m_bias = bd;
      if (wwe && int'(wa) < N) m_w[wa] = wd;
    end
    in_valid = 1'b0; w_we = 1'b0; b_we = 1'b0; rst = 1'b0;
  endtask

  task automatic inp(input logic [11:0] d);
    step(1'b1, d, 1'b0, 4'd0, 12'd0, 1'b0, 23'd0, 1'b0);
  endtask

  task automatic wr_w(input logic [3:0] a, input logic [11:0] d);
    step(1'b0, 12'd0, 1'b1, a, d, 1'b0, 23'd0, 1'b0);
  endtask

  task automatic wr_b(input logic [22:0] d);
    step(1'b0, 12'd0, 1'b0, 4'd0, 12'd0, 1'b1, d, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 12'd0, 1'b0, 4'd0, 12'd0, 1'b0, 23'd0, 1'b0);
  endtask

  task automatic set_w3(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
    wr_w(4'd0, a); wr_w(4'd1, b); wr_w(4'd2, c);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        if (q_dat.size() == 0) begin
          chk("unexpected_pulse", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          chk("out_data", 32'(out_data), 32'(q_dat[0]));
          chk("pulse_cycle", cyc, q_cyc[0]);
          hold_exp = q_dat[0];
          void'(q_dat.pop_front());
          void'(q_cyc.pop_front());
        end
      end else begin
        chk("hold", 32'(out_data), 32'(hold_exp));
      end
    end
  end

  initial begin
    model_reset();
    step(1'b0, 12'd0, 1'b0, 4'd0, 12'd0, 1'b0, 23'd0, 1'b1);
    step(1'b0, 12'd0, 1'b0, 4'd0, 12'd0, 1'b0, 23'd0, 1'b1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    mon_en = 1'b1;

    // Positive vector
    set_w3(12'h400, 12'h400, 12'h400);
    wr_b(23'h0);
    inp(12'h400); inp(12'h400); inp(12'h400);
    idle();
    chk("pos_vec", 32'(hold_exp), 32'h300000);

    // Negative vector
    set_w3(12'hC00, 12'hC00, 12'hC00);
    inp(12'h400); inp(12'h400); inp(12'h400);
    idle();
`ifdef NEURON_RELU_EN
    chk("neg_vec", 32'(hold_exp), 32'h000000);
`else
    chk("neg_vec", 32'(hold_exp), 32'h700000);
`endif

    // Saturation
    set_w3(12'h7FF, 12'h7FF, 12'h7FF);
    inp(12'h7FF); inp(12'h7FF); inp(12'h7FF);
    idle();
    chk("sat_vec", 32'(hold_exp), 32'h3FFFFF);

    // Cancellation, negative-zero input, bias
    wr_b(23'h000010);
    set_w3(12'h400, 12'hC00, 12'h400);
    inp(12'h400); inp(12'h400); inp(12'h800);
    idle();
    chk("cancel_vec", 32'(hold_exp), 32'h000010);

    // Reset mid-vector discards partial sum and weights
    inp(12'h7FF); inp(12'h7FF);
    step(1'b0, 12'd0, 1'b0, 4'd0, 12'd0, 1'b0, 23'd0, 1'b1);
    set_w3(12'h400, 12'h400, 12'h400);
    inp(12'h200); inp(12'h200); inp(12'h200);
    idle();
    chk("rst_mid_vec", 32'(hold_exp), 32'h180000);

    // Back-to-back vectors; weight[0] rewritten in the cycle vector 1 consumes it
    step(1'b1, 12'h400, 1'b1, 4'd0, 12'h000, 1'b0, 23'd0, 1'b0);
    inp(12'h400); inp(12'h400);
    inp(12'h400); inp(12'h400); inp(12'h400);
    idle();
    chk("b2b_vec2", 32'(hold_exp), 32'h200000);

    // Out-of-range weight writes ignored; mid-vector bias write deferred
    set_w3(12'h100, 12'h900, 12'h300);
    wr_w(4'd3, 12'h7FF); wr_w(4'd15, 12'h7FF);
    wr_b(23'h400000 | 23'h000123);
    inp(12'h7FF);
    step(1'b1, 12'h055, 1'b0, 4'd0, 12'd0, 1'b1, 23'h0ABCDE, 1'b0);
    inp(12'h8AA);
    step(1'b1, 12'h3C3, 1'b0, 4'd0, 12'd0, 1'b1, 23'h000000, 1'b0);
    inp(12'hFFF); inp(12'h001);
    idle();

    // Random vectors with random gaps and writes
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) == 0) idle();
        step(1'b1, 12'($urandom), 1'($urandom), 4'($urandom_range(0, 4)), 12'($urandom),
             1'($urandom_range(0, 3) == 0), 23'($urandom), 1'b0);
      end
    end
    idle(); idle(); idle();
    chk("queue_drained", q_dat.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
